// File: rtl/cpu_pkg.sv
// Shared CPU constants: default datapath widths, write-data select codes and
// payload field indices used by the pipeline registers and the WB stage.
// No logic; only localparams consumed via import cpu_pkg::*.
package cpu_pkg;

  localparam int DEF_XLEN       = 32;
  localparam int DEF_NUM_FIELDS = 4;
  localparam int GRF_ADDR_W     = 5;
  localparam int DEF_SEL_W      = 3;

  // Write-data select codes carried to the GRF write mux
  localparam logic [DEF_SEL_W-1:0] WD_ALU  = 3'd0;
  localparam logic [DEF_SEL_W-1:0] WD_LOAD = 3'd1;
  localparam logic [DEF_SEL_W-1:0] WD_LINK = 3'd2;

  // Payload field k occupies bits [k*XLEN +: XLEN]
  localparam int FLD_PC    = 0;
  localparam int FLD_INSTR = 1;
  localparam int FLD_RD    = 2;
  localparam int FLD_AO    = 3;

endpackage

// File: rtl/pipe_slot.sv
// Single valid+payload register with load and clear enables.
// Latency: one cycle from load to q/valid. Backpressure: none, the parent decides when to load.
// Ports: clk, reset (async active-low), load/clr enables, d in, valid/q out. clr beats load.
module pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      q     <= '0;
    end else begin
      if (clr) begin
        valid <= 1'b0;
      end else if (load) begin
        valid <= 1'b1;
      end
      // A killed load leaves the payload untouched; only valid matters then.
      if (load && !clr) begin
        q <= d;
      end
    end
  end

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register with valid/ready handshake, flush and forwarding tap.
// Latency: one cycle, no combinational in->out path. Backpressure: SKID=1 uses a
// 2-entry skid with registered in_ready; SKID=0 is a single slot with in_ready = !out_valid | out_ready.
// Ports: clk, reset (async active-low), flush, in_* (MEM side), out_* (WB side), fwd_* tap, occupancy.
module mem_wb_pipe
  import cpu_pkg::*;
#(
  parameter int XLEN       = DEF_XLEN,
  parameter int NUM_FIELDS = DEF_NUM_FIELDS,
  parameter int REG_ADDR_W = GRF_ADDR_W,
  parameter int SEL_W      = DEF_SEL_W,
  parameter int SKID       = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_FIELDS*XLEN-1:0] in_data,
  input  logic [REG_ADDR_W-1:0]      in_wa,
  input  logic                       in_we,
  input  logic [SEL_W-1:0]           in_sel,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_FIELDS*XLEN-1:0] out_data,
  output logic [REG_ADDR_W-1:0]      out_wa,
  output logic                       out_we,
  output logic [SEL_W-1:0]           out_sel,
  output logic [REG_ADDR_W-1:0]      fwd_wa,
  output logic                       fwd_we,
  output logic [1:0]                 occupancy
);

  localparam int DW = NUM_FIELDS * XLEN;
  localparam int PW = DW + REG_ADDR_W + 1 + SEL_W;

  logic [PW-1:0] in_pay;
  logic [PW-1:0] head_d;
  logic [PW-1:0] head_q;
  logic          head_vld;
  logic          head_load;
  logic          head_clr;
  logic          head_we;
  logic          in_xfer;
  logic          out_xfer;

  assign in_pay   = {in_data, in_wa, in_we, in_sel};
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = head_vld & out_ready;

  pipe_slot #(.W(PW)) u_head (
    .clk   (clk),
    .reset (reset),
    .load  (head_load),
    .clr   (head_clr),
    .d     (head_d),
    .valid (head_vld),
    .q     (head_q)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic [PW-1:0] skid_q;
      logic          skid_vld;
      logic          skid_load;
      logic          skid_clr;
      logic          rdy_q;
      logic          rdy_nxt;

      // in_ready is registered, so an input transfer never coincides with a
      // full skid slot; the head therefore refills from either skid or input.
      always_comb begin
        head_d    = skid_vld ? skid_q : in_pay;
        head_load = (out_xfer & skid_vld) | (in_xfer & (~head_vld | out_xfer));
        head_clr  = flush | (out_xfer & ~in_xfer & ~skid_vld);
        skid_load = in_xfer & head_vld & ~out_xfer;
        skid_clr  = flush | (out_xfer & skid_vld);
        // Ready next cycle exactly when the skid slot will be empty.
        rdy_nxt   = flush | (skid_vld ? out_xfer : ~skid_load);
      end

      pipe_slot #(.W(PW)) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (skid_load),
        .clr   (skid_clr),
        .d     (in_pay),
        .valid (skid_vld),
        .q     (skid_q)
      );

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          rdy_q <= 1'b1;
        end else begin
          rdy_q <= rdy_nxt;
        end
      end

      assign in_ready  = rdy_q;
      assign occupancy = {1'b0, head_vld} + {1'b0, skid_vld};
    end else begin : g_single
      always_comb begin
        head_d    = in_pay;
        head_load = in_xfer;
        head_clr  = flush | (out_xfer & ~in_xfer);
      end

      assign in_ready  = ~head_vld | out_ready;
      assign occupancy = {1'b0, head_vld};
    end
  endgenerate

  assign {out_data, out_wa, head_we, out_sel} = head_q;
  assign out_valid = head_vld;
  // Bubbles and $zero destinations must never reach the GRF.
  assign out_we    = head_we & head_vld & (out_wa != '0);
  assign fwd_wa    = out_wa;
  assign fwd_we    = out_we;

endmodule

// File: tb/tb_mem_wb_pipe.sv
module tb_mem_wb_pipe;
  import cpu_pkg::*;

  localparam int XL = 32;
  localparam int NF = 4;
  localparam int DW = NF * XL;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, flush;

  logic          s_in_valid, s_in_ready, s_in_we, s_out_valid, s_out_ready, s_out_we, s_fwd_we;
  logic [DW-1:0] s_in_data, s_out_data;
  logic [4:0]    s_in_wa, s_out_wa, s_fwd_wa;
  logic [2:0]    s_in_sel, s_out_sel;
  logic [1:0]    s_occ;

  logic          p_in_valid, p_in_ready, p_in_we, p_out_valid, p_out_ready, p_out_we, p_fwd_we;
  logic [DW-1:0] p_in_data, p_out_data;
  logic [4:0]    p_in_wa, p_out_wa, p_fwd_wa;
  logic [2:0]    p_in_sel, p_out_sel;
  logic [1:0]    p_occ;

  mem_wb_pipe #(.XLEN(XL), .NUM_FIELDS(NF), .REG_ADDR_W(5), .SEL_W(3), .SKID(1)) u_skid (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_wa(s_in_wa),
    .in_we(s_in_we), .in_sel(s_in_sel),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .out_wa(s_out_wa),
    .out_we(s_out_we), .out_sel(s_out_sel), .fwd_wa(s_fwd_wa), .fwd_we(s_fwd_we), .occupancy(s_occ)
  );

  mem_wb_pipe #(.XLEN(XL), .NUM_FIELDS(NF), .REG_ADDR_W(5), .SEL_W(3), .SKID(0)) u_pass (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(p_in_valid), .in_ready(p_in_ready), .in_data(p_in_data), .in_wa(p_in_wa),
    .in_we(p_in_we), .in_sel(p_in_sel),
    .out_valid(p_out_valid), .out_ready(p_out_ready), .out_data(p_out_data), .out_wa(p_out_wa),
    .out_we(p_out_we), .out_sel(p_out_sel), .fwd_wa(p_fwd_wa), .fwd_we(p_fwd_we), .occupancy(p_occ)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [4:0]    wa;
    logic          we;
    logic [2:0]    sel;
  } exp_t;

  typedef struct {
    bit          iv, orr, fl;
    logic [31:0] pc, ao;
    logic [4:0]  wa;
    bit          we;
    logic [2:0]  sel;
    bit          e_ov;
    int          e_occ;
    bit          e_ir;
    bit          e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_pc;
  } vec_t;

  exp_t sq[$];
  exp_t pq[$];
  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   p_pops = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mkdata(input logic [31:0] pc, input logic [31:0] ao);
    logic [DW-1:0] d;
    d = '0;
    d[FLD_PC*XL +: XL]    = pc;
    d[FLD_INSTR*XL +: XL] = ~pc;
    d[FLD_RD*XL +: XL]    = pc ^ 32'hA5A5_0000;
    d[FLD_AO*XL +: XL]    = ao;
    return d;
  endfunction

  task automatic addv(input bit iv, input bit orr, input bit fl, input logic [31:0] pc,
                      input logic [31:0] ao, input logic [4:0] wa, input bit we, input logic [2:0] sel,
                      input bit e_ov, input int e_occ, input bit e_ir, input bit e_we,
                      input logic [4:0] e_wa, input logic [31:0] e_pc);
    vec_t v;
    v.iv = iv; v.orr = orr; v.fl = fl; v.pc = pc; v.ao = ao; v.wa = wa; v.we = we; v.sel = sel;
    v.e_ov = e_ov; v.e_occ = e_occ; v.e_ir = e_ir; v.e_we = e_we; v.e_wa = e_wa; v.e_pc = e_pc;
    tbl.push_back(v);
  endtask

  // One clock of the SKID=1 instance: drive, score the edge, advance to edge+1.
  task automatic skid_cycle(input bit iv, input bit orr, input bit fl, input logic [31:0] pc,
                            input logic [31:0] ao, input logic [4:0] wa, input bit we, input logic [2:0] sel);
    exp_t e;
    s_in_valid = iv; s_out_ready = orr; flush = fl;
    s_in_data = mkdata(pc, ao); s_in_wa = wa; s_in_we = we; s_in_sel = sel;
    #1;
    if (s_out_valid && orr && !fl) begin
      if (sq.size() == 0) begin
        chk("skid_unexpected_out", s_out_data, '0);
      end else begin
        e = sq.pop_front();
        chk("skid_sb_data", s_out_data, e.data);
        chk("skid_sb_wa", DW'(s_out_wa), DW'(e.wa));
        chk("skid_sb_we", DW'(s_out_we), DW'(e.we));
        chk("skid_sb_sel", DW'(s_out_sel), DW'(e.sel));
      end
    end
    if (fl) begin
      sq.delete();
    end else if (iv && s_in_ready) begin
      e.data = mkdata(pc, ao); e.wa = wa; e.we = we && (wa != 5'd0); e.sel = sel;
      sq.push_back(e);
    end
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  // One clock of the SKID=0 instance, with an expected in_ready for the cycle.
  task automatic pass_cycle(input bit iv, input bit orr, input logic [31:0] pc, input logic [4:0] wa,
                            input bit exp_ir);
    exp_t e;
    p_in_valid = iv; p_out_ready = orr;
    p_in_data = mkdata(pc, pc + 32'h10); p_in_wa = wa; p_in_we = 1'b1; p_in_sel = WD_ALU;
    #1;
    chk("pass_in_ready", DW'(p_in_ready), DW'(exp_ir));
    if (p_out_valid && orr) begin
      if (pq.size() == 0) begin
        chk("pass_unexpected_out", p_out_data, '0);
      end else begin
        e = pq.pop_front();
        p_pops++;
        chk("pass_sb_data", p_out_data, e.data);
        chk("pass_sb_we", DW'(p_out_we), DW'(e.we));
      end
    end
    if (iv && p_in_ready) begin
      e.data = mkdata(pc, pc + 32'h10); e.wa = wa; e.we = (wa != 5'd0); e.sel = WD_ALU;
      pq.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0;
    s_in_valid = 0; s_out_ready = 0; s_in_data = '0; s_in_wa = '0; s_in_we = 0; s_in_sel = '0;
    p_in_valid = 0; p_out_ready = 0; p_in_data = '0; p_in_wa = '0; p_in_we = 0; p_in_sel = '0;

    // Reset state
    #12;
    chk("rst_out_valid", DW'(s_out_valid), '0);
    chk("rst_occ", DW'(s_occ), '0);
    chk("rst_in_ready", DW'(s_in_ready), DW'(1));
    chk("rst_out_we", DW'(s_out_we), '0);
    chk("rst_out_data", s_out_data, '0);
    chk("rst_pass_in_ready", DW'(p_in_ready), DW'(1));
    chk("rst_pass_out_valid", DW'(p_out_valid), '0);
    @(posedge clk); #1;
    reset = 1'b1;

    //    iv orr fl pc            ao            wa  we sel      | ov occ ir we wa  head_pc
    addv(1, 1, 0, 32'h3000, 32'h1234, 5'd8,  1, WD_ALU,  1, 1, 1, 1, 5'd8,  32'h3000);
    addv(0, 1, 0, 32'h0,    32'h0,    5'd0,  0, WD_ALU,  0, 0, 1, 0, 5'd0,  32'h0);
    // back-pressure: A then B, hold 5 cycles, drain
    addv(1, 0, 0, 32'h4000, 32'hAAAA, 5'd3,  1, WD_ALU,  1, 1, 1, 1, 5'd3,  32'h4000);
    addv(1, 0, 0, 32'h4004, 32'hBBBB, 5'd4,  1, WD_LOAD, 1, 2, 0, 1, 5'd3,  32'h4000);
    for (int i = 0; i < 5; i++)
      addv(0, 0, 0, 32'h0,  32'h0,    5'd0,  0, WD_ALU,  1, 2, 0, 1, 5'd3,  32'h4000);
    addv(0, 1, 0, 32'h0,    32'h0,    5'd0,  0, WD_ALU,  1, 1, 1, 1, 5'd4,  32'h4004);
    addv(0, 1, 0, 32'h0,    32'h0,    5'd0,  0, WD_ALU,  0, 0, 1, 0, 5'd0,  32'h0);
    // flush at FULL with C presented, then flush at ONE with in_ready=1
    addv(1, 0, 0, 32'h5000, 32'h1,    5'd5,  1, WD_ALU,  1, 1, 1, 1, 5'd5,  32'h5000);
    addv(1, 0, 0, 32'h5004, 32'h2,    5'd6,  1, WD_ALU,  1, 2, 0, 1, 5'd5,  32'h5000);
    addv(1, 0, 1, 32'h6000, 32'h3,    5'd7,  1, WD_ALU,  0, 0, 1, 0, 5'd0,  32'h0);
    addv(1, 0, 0, 32'h7000, 32'h4,    5'd9,  1, WD_ALU,  1, 1, 1, 1, 5'd9,  32'h7000);
    addv(1, 0, 1, 32'h7004, 32'h5,    5'd10, 1, WD_ALU,  0, 0, 1, 0, 5'd0,  32'h0);
    addv(0, 1, 0, 32'h0,    32'h0,    5'd0,  0, WD_ALU,  0, 0, 1, 0, 5'd0,  32'h0);
    // $zero gating
    addv(1, 0, 0, 32'h8000, 32'h6,    5'd0,  1, WD_LOAD, 1, 1, 1, 0, 5'd0,  32'h8000);
    addv(0, 1, 0, 32'h0,    32'h0,    5'd0,  0, WD_ALU,  0, 0, 1, 0, 5'd0,  32'h0);
    // ONE with simultaneous in/out: head replaced
    addv(1, 0, 0, 32'h9000, 32'h7,    5'd10, 1, WD_ALU,  1, 1, 1, 1, 5'd10, 32'h9000);
    addv(1, 1, 0, 32'h9004, 32'h8,    5'd11, 1, WD_LINK, 1, 1, 1, 1, 5'd11, 32'h9004);
    // we=0 entry stays non-writing
    addv(1, 1, 0, 32'hA000, 32'h9,    5'd12, 0, WD_LINK, 1, 1, 1, 0, 5'd12, 32'hA000);
    addv(0, 1, 0, 32'h0,    32'h0,    5'd0,  0, WD_ALU,  0, 0, 1, 0, 5'd0,  32'h0);

    foreach (tbl[i]) begin
      skid_cycle(tbl[i].iv, tbl[i].orr, tbl[i].fl, tbl[i].pc, tbl[i].ao, tbl[i].wa, tbl[i].we, tbl[i].sel);
      chk($sformatf("v%0d_out_valid", i), DW'(s_out_valid), DW'(tbl[i].e_ov));
      chk($sformatf("v%0d_occ", i), DW'(s_occ), DW'(tbl[i].e_occ));
      chk($sformatf("v%0d_in_ready", i), DW'(s_in_ready), DW'(tbl[i].e_ir));
      chk($sformatf("v%0d_out_we", i), DW'(s_out_we), DW'(tbl[i].e_we));
      chk($sformatf("v%0d_fwd_we", i), DW'(s_fwd_we), DW'(tbl[i].e_we));
      if (tbl[i].e_ov) begin
        chk($sformatf("v%0d_fwd_wa", i), DW'(s_fwd_wa), DW'(tbl[i].e_wa));
        chk($sformatf("v%0d_head_pc", i), DW'(s_out_data[FLD_PC*XL +: XL]), DW'(tbl[i].e_pc));
      end
    end
    chk("skid_sb_empty", DW'(sq.size()), '0);

    // Asynchronous reset mid-stream at occupancy 2
    skid_cycle(1, 0, 0, 32'hB000, 32'hC, 5'd13, 1, WD_ALU);
    skid_cycle(1, 0, 0, 32'hB004, 32'hD, 5'd14, 1, WD_ALU);
    chk("arst_pre_occ", DW'(s_occ), DW'(2));
    #2 reset = 1'b0;
    #1;
    chk("arst_out_valid", DW'(s_out_valid), '0);
    chk("arst_occ", DW'(s_occ), '0);
    chk("arst_out_we", DW'(s_out_we), '0);
    chk("arst_in_ready", DW'(s_in_ready), DW'(1));
    chk("arst_out_data", s_out_data, '0);
    sq.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    skid_cycle(0, 1, 0, 32'h0, 32'h0, 5'd0, 0, WD_ALU);
    chk("arst_post_occ", DW'(s_occ), '0);

    // SKID=0 streaming, then a stall with combinational in_ready
    for (int i = 0; i < 10; i++)
      pass_cycle(1, 1, 32'h3000 + 32'(i) * 32'd4, 5'(i + 1), 1'b1);
    pass_cycle(0, 1, 32'h0, 5'd0, 1'b1);
    chk("pass_stream_count", DW'(p_pops), DW'(10));
    chk("pass_stream_occ", DW'(p_occ), '0);
    pass_cycle(1, 0, 32'hC000, 5'd1, 1'b1);
    chk("pass_stall_occ", DW'(p_occ), DW'(1));
    pass_cycle(1, 0, 32'hC004, 5'd2, 1'b0);
    chk("pass_stall_head", DW'(p_out_data[FLD_PC*XL +: XL]), DW'(32'hC000));
    pass_cycle(1, 1, 32'hC004, 5'd2, 1'b1);
    pass_cycle(0, 1, 32'h0, 5'd0, 1'b1);
    chk("pass_sb_empty", DW'(pq.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_wb_pipe.md
Name: mem_wb_pipe

Overview:
Parametrised successor to the fixed MEM/WB pipeline register. It adds a valid/ready handshake, stall back-pressure, flush, an optional 2-entry skid buffer, multi-field payload and a forwarding tap.
It sits between the MEM stage and the GRF write port. It carries the write-back control (write address, write enable, write-data select) alongside the data fields.
Downstream hazard logic reads the forwarding tap to see the value that is about to be written back.

Parameters:
XLEN, 32, width of one payload field (PC, instruction, read data, ALU output, ...)
NUM_FIELDS, 4, number of XLEN-wide payload fields carried
REG_ADDR_W, 5, GRF write-address width
SEL_W, 3, width of the write-data select code
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational ready

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous reset, active-low (0 = reset)
flush  input  1  synchronous kill of all held entries
in_valid  input  1  MEM stage presents an entry
in_ready  output  1  stage can accept an entry this cycle
in_data  input  NUM_FIELDS*XLEN  payload; field k occupies bits [k*XLEN +: XLEN]
in_wa  input  REG_ADDR_W  destination register
in_we  input  1  entry writes the GRF
in_sel  input  SEL_W  write-data select (0 = ALU, 1 = load, 2 = link PC+8)
out_valid  output  1  head entry valid
out_ready  input  1  WB consumes the head entry
out_data  output  NUM_FIELDS*XLEN  head payload
out_wa  output  REG_ADDR_W  head destination
out_we  output  1  in_we of the head entry AND out_valid AND (out_wa != 0)
out_sel  output  SEL_W  head select code
fwd_wa  output  REG_ADDR_W  equals out_wa
fwd_we  output  1  equals out_we
occupancy  output  2  entries held (0..2; max 1 when SKID=0)

Behaviour:
- Reset (reset=0, asynchronous): all valid bits 0, all payload/control registers 0.
  - Outputs: out_valid=0, out_we=0, occupancy=0, out_* all 0.
  - in_ready=1 during reset when SKID=1.
- Reset release is synchronised by the consumer; the block itself samples normally from the first clk edge with reset=1.
- Transfers:
  - Input transfer: in_valid & in_ready at a rising edge.
  - Output transfer: out_valid & out_ready at a rising edge.
- Latency: an accepted entry appears on out_* in the cycle after acceptance. There is no combinational in→out path.
- Ordering: strict FIFO; entries never reorder or duplicate.
- SKID=1 state machine, state = occupancy:
  - EMPTY:
    - input transfer → ONE.
  - ONE:
    - input and output transfer → ONE; head replaced by the new entry.
    - input transfer only → FULL; new entry goes to the skid slot.
    - output transfer only → EMPTY.
  - FULL:
    - output transfer → ONE; skid entry moves to head.
    - no input transfer is possible.
  - in_ready = (state != FULL), registered; never depends on out_ready combinationally.
- SKID=0:
  - in_ready = !out_valid | out_ready (combinational).
  - Head loads on input transfer; otherwise it clears valid on output transfer.
- Stall: out_ready=0 holds the head and all its fields bit-stable for as many cycles as it lasts.
- Flush:
  - flush=1 at an edge clears all valid bits; next cycle occupancy=0 and out_we=0.
  - An input presented in the same cycle is dropped, even if in_ready=1.
  - Flush takes priority over every transfer.
  - Payload registers need not clear.
- Write-enable gating:
  - out_we is 0 whenever out_valid=0 or out_wa=0.
  - So $zero writes and bubbles never reach the GRF.
- Reset asserted mid-operation: everything is dropped immediately, asynchronously; no entry survives.
- Width rules: fields are passed bit-exact; no extension or arithmetic is performed.

Decomposition:
- Shared package `cpu_pkg`:
  - XLEN default.
  - Write-data select constants WD_ALU=0, WD_LOAD=1, WD_LINK=2.
  - GRF address width.
  - Field index constants FLD_PC=0, FLD_INSTR=1, FLD_RD=2, FLD_AO=3.
- One sub-module, `pipe_slot`: a single valid+payload register with load/clear enables, instantiated once (SKID=0) or twice (SKID=1).

Test Plan:
1. Reset/pass-through: hold reset=0 → out_valid=0, occupancy=0, in_ready=1. Release reset and push {PC=0x3000, AO=0x1234}, wa=8, we=1, out_ready=1 → next cycle out_data carries PC=0x3000 and AO=0x1234, out_we=1, fwd_wa=8.
2. Back-pressure with SKID=1: hold out_ready=0 and push A, then B.
   - After B: occupancy=2, in_ready=0, head=A, stable for 5 cycles.
   - Raise out_ready → A then B drain on consecutive cycles.
   - in_ready returns to 1 the cycle after A leaves.
3. Flush: at occupancy=2 assert flush together with in_valid=1 (entry C) → next cycle occupancy=0 and out_valid=0; C never appears on the outputs.
4. $zero gating: push wa=0, we=1, sel=WD_LOAD → out_valid=1 but out_we=0 and fwd_we=0.
5. Streaming with SKID=0: in_valid=1 and out_ready=1 for 10 cycles with PC incrementing by 4 from 0x3000 → one entry out per cycle with PC in order, in_ready=1 throughout.
6. Asynchronous reset mid-stream: drop reset between edges while occupancy=2 → out_valid and occupancy go to 0 immediately, without waiting for a clk edge.
